// File: rtl/calc1_port_scheduler.sv
// calc1_port_scheduler: four-port front end sharing one calc1 ALU, round-robin granted,
// with a WAIT timeout that turns a hung operation into response code 3.
module calc1_port_scheduler #(
    parameter int TIMEOUT = 15
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic [3:0]  req1_cmd_in,
    input  logic [3:0]  req2_cmd_in,
    input  logic [3:0]  req3_cmd_in,
    input  logic [3:0]  req4_cmd_in,
    input  logic [31:0] req1_data_in,
    input  logic [31:0] req2_data_in,
    input  logic [31:0] req3_data_in,
    input  logic [31:0] req4_data_in,
    output logic [1:0]  out_resp1,
    output logic [1:0]  out_resp2,
    output logic [1:0]  out_resp3,
    output logic [1:0]  out_resp4,
    output logic [31:0] out_data1,
    output logic [31:0] out_data2,
    output logic [31:0] out_data3,
    output logic [31:0] out_data4,
    output logic [3:0]  alu_cmd,
    output logic [31:0] alu_op1,
    output logic [31:0] alu_op2,
    output logic        alu_start,
    input  logic        alu_done,
    input  logic [1:0]  alu_resp,
    input  logic [31:0] alu_result
);
    typedef enum logic [1:0] {P_IDLE, P_OP2, P_PEND, P_BUSY} port_t;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} sched_t;

    logic [3:0]  cmd_in [4];
    logic [31:0] data_in [4];
    logic [3:0]  cmd_q [4];
    logic [31:0] op1_q [4];
    logic [31:0] op2_q [4];
    logic [1:0]  resp_q [4];
    logic [31:0] rdata_q [4];
    port_t       pstate [4];
    port_t       pstate_nx [4];
    sched_t      state, state_nx;
    logic [1:0]  rr, gnt, sel;
    logic [7:0]  cnt;
    logic        any_pend, grant, fin;

    assign cmd_in  = '{req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in};
    assign data_in = '{req1_data_in, req2_data_in, req3_data_in, req4_data_in};
    assign out_resp1 = resp_q[0];
    assign out_resp2 = resp_q[1];
    assign out_resp3 = resp_q[2];
    assign out_resp4 = resp_q[3];
    assign out_data1 = rdata_q[0];
    assign out_data2 = rdata_q[1];
    assign out_data3 = rdata_q[2];
    assign out_data4 = rdata_q[3];

    // Scan downward so the PEND port closest to rr (smallest offset) wins.
    always_comb begin
        sel = rr;
        any_pend = 1'b0;
        for (int k = 3; k >= 0; k--)
            if (pstate[rr + 2'(k)] == P_PEND) begin
                sel = rr + 2'(k);
                any_pend = 1'b1;
            end
    end

    assign grant = state == S_IDLE && any_pend;
    assign fin   = state == S_WAIT && (alu_done || cnt == 8'(TIMEOUT));

    always_comb begin
        state_nx = state == S_IDLE  ? (any_pend ? S_ISSUE : S_IDLE) :
                   state == S_ISSUE ? S_WAIT :
                   state == S_WAIT  ? (fin ? S_RESP : S_WAIT) : S_IDLE;
        for (int i = 0; i < 4; i++)
            pstate_nx[i] = pstate[i] == P_IDLE ? (cmd_in[i] != 4'd0 ? P_OP2 : P_IDLE) :
                           pstate[i] == P_OP2  ? P_PEND :
                           pstate[i] == P_PEND ? (grant && sel == 2'(i) ? P_BUSY : P_PEND) :
                           (state == S_RESP && gnt == 2'(i) ? P_IDLE : P_BUSY);
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            for (int i = 0; i < 4; i++) pstate[i] <= P_IDLE;
        end else begin
            state <= state_nx;
            for (int i = 0; i < 4; i++) pstate[i] <= pstate_nx[i];
        end
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            rr        <= 2'd0;
            gnt       <= 2'd0;
            cnt       <= 8'd0;
            alu_start <= 1'b0;
            alu_cmd   <= 4'd0;
            alu_op1   <= 32'd0;
            alu_op2   <= 32'd0;
            for (int i = 0; i < 4; i++) begin
                cmd_q[i]   <= 4'd0;
                op1_q[i]   <= 32'd0;
                op2_q[i]   <= 32'd0;
                resp_q[i]  <= 2'd0;
                rdata_q[i] <= 32'd0;
            end
        end else begin
            alu_start <= grant;
            if (grant) begin
                gnt     <= sel;
                alu_cmd <= cmd_q[sel];
                alu_op1 <= op1_q[sel];
                alu_op2 <= op2_q[sel];
            end
            // cnt counts completed WAIT cycles; it is zero on entry to WAIT
            cnt <= state == S_WAIT ? cnt + 8'd1 : 8'd0;
            if (state == S_RESP) rr <= gnt + 2'd1;
            for (int i = 0; i < 4; i++) begin
                resp_q[i]  <= fin && gnt == 2'(i) ? (alu_done ? alu_resp : 2'd3) : 2'd0;
                rdata_q[i] <= fin && gnt == 2'(i) && alu_done ? alu_result : 32'd0;
                if (pstate[i] == P_IDLE && cmd_in[i] != 4'd0) begin
                    cmd_q[i] <= cmd_in[i];
                    op1_q[i] <= data_in[i];
                end
                if (pstate[i] == P_OP2) op2_q[i] <= data_in[i];
            end
        end
    end
endmodule
